// File: rtl/queueing_domain_v2.sv
// queueing_domain_v2
//   Per-core queueing stage between the dispatcher and the EDF scheduler.
//   Each queue is an independent show-ahead FIFO with occupancy reporting,
//   a high/low threshold throttle FSM and a saturating drop counter.
//   A push into a full queue is accepted when that queue pops in the same cycle.
//
// Ports
//   clock                          sole clock, rising edge
//   reset                          asynchronous, active-low
//   queues_higher_threshold  [N*RS] per-queue kill-assert level (0 disables)
//   queues_lower_threshold   [N*RS] per-queue kill-release level
//   dispatcher_to_queues_packets [PORTS*DS] queue i reads port i/QUEUES_PER_PORT
//   dispatcher_to_queues_valid   [N] push request per queue
//   scheduler_to_queues_consumed [N] pop request per queue
//   drop_count_clear               synchronous clear of all drop counters
//   queues_to_selector_packets [N*DS] head entry per queue (stale when empty)
//   empty / full / lastElem      [N] count==0 / count==QUEUE_LENGTH / count==1
//   occupancy                 [N*CW] current count per queue
//   Qs_kill_the_core             [N] throttle request per queue
//   drop_count               [N*RS] rejected pushes per queue, saturating
module queueing_domain_v2 #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int QUEUES_PER_PORT  = 2,
  parameter int REGISTER_SIZE    = 32,
  parameter int DATA_SIZE        = 678,
  parameter int QUEUE_LENGTH     = 16,
  localparam int PORTS = NUMBER_OF_QUEUES / QUEUES_PER_PORT,
  localparam int CW    = $clog2(QUEUE_LENGTH + 1)
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NUMBER_OF_QUEUES*REGISTER_SIZE-1:0] queues_higher_threshold,
  input  logic [NUMBER_OF_QUEUES*REGISTER_SIZE-1:0] queues_lower_threshold,
  input  logic [PORTS*DATA_SIZE-1:0]            dispatcher_to_queues_packets,
  input  logic [NUMBER_OF_QUEUES-1:0]           dispatcher_to_queues_valid,
  input  logic [NUMBER_OF_QUEUES-1:0]           scheduler_to_queues_consumed,
  input  logic                                  drop_count_clear,
  output logic [NUMBER_OF_QUEUES*DATA_SIZE-1:0] queues_to_selector_packets,
  output logic [NUMBER_OF_QUEUES-1:0]           empty,
  output logic [NUMBER_OF_QUEUES-1:0]           full,
  output logic [NUMBER_OF_QUEUES-1:0]           lastElem,
  output logic [NUMBER_OF_QUEUES*CW-1:0]        occupancy,
  output logic [NUMBER_OF_QUEUES-1:0]           Qs_kill_the_core,
  output logic [NUMBER_OF_QUEUES*REGISTER_SIZE-1:0] drop_count
);

  localparam int PW = $clog2(QUEUE_LENGTH);

  typedef enum logic {NORMAL, KILL} throttle_e;

  for (genvar q = 0; q < NUMBER_OF_QUEUES; q++) begin : g_queue
    logic [DATA_SIZE-1:0]     mem [QUEUE_LENGTH];
    logic [PW-1:0]            rd_ptr, wr_ptr;
    logic [CW-1:0]            count;
    logic                     is_empty, is_full;
    logic                     pop, push, reject;
    logic [REGISTER_SIZE-1:0] count_ext, higher, lower, drops;
    throttle_e                state_q, state_d;
    logic                     kill;

    assign is_empty = (count == '0);
    assign is_full  = (count == CW'(QUEUE_LENGTH));
    assign pop      = scheduler_to_queues_consumed[q] & ~is_empty;
    // A pop frees the slot the push needs, so full + pop still accepts.
    assign push     = dispatcher_to_queues_valid[q] & (~is_full | pop);
    assign reject   = dispatcher_to_queues_valid[q] & is_full & ~pop;

    // Storage is not reset; the pointers/count alone define validity.
    always_ff @(posedge clock) begin
      if (push)
        mem[wr_ptr] <= dispatcher_to_queues_packets[(q / QUEUES_PER_PORT) * DATA_SIZE +: DATA_SIZE];
    end

    // Pointer width equals log2(QUEUE_LENGTH), so increment wraps naturally.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end

    assign queues_to_selector_packets[q*DATA_SIZE +: DATA_SIZE] = mem[rd_ptr];
    assign empty[q]                  = is_empty;
    assign full[q]                   = is_full;
    assign lastElem[q]               = (count == CW'(1));
    assign occupancy[q*CW +: CW]     = count;

    assign count_ext = REGISTER_SIZE'(count);
    assign higher    = queues_higher_threshold[q*REGISTER_SIZE +: REGISTER_SIZE];
    assign lower     = queues_lower_threshold[q*REGISTER_SIZE +: REGISTER_SIZE];

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= NORMAL;
      else        state_q <= state_d;
    end

    always_comb begin
      state_d = state_q;
      case (state_q)
        NORMAL:  if (higher != '0 && count_ext >= higher) state_d = KILL;
        KILL:    if (higher == '0 || count_ext <= lower)  state_d = NORMAL;
        default: state_d = NORMAL;
      endcase
    end

    always_comb begin
      kill = (state_q == KILL);
    end

    assign Qs_kill_the_core[q] = kill;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset)                      drops <= '0;
      else if (drop_count_clear)       drops <= '0;
      else if (reject && drops != '1)  drops <= drops + REGISTER_SIZE'(1);
    end

    assign drop_count[q*REGISTER_SIZE +: REGISTER_SIZE] = drops;
  end

endmodule
